// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard controller: halt-FSM encoding,
// in-flight counter width and the pipeline NOP.
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_t;

    localparam int          OUT_W    = 3;
    localparam logic [31:0] NOP_INSN = 32'h00000033;

    // A simultaneous issue and completion leaves the count unchanged.
    function automatic logic [OUT_W-1:0] next_count(
        input logic [OUT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [OUT_W-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            res = cnt - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register pending-load scoreboard and in-flight load counter;
// flags RAW, WAW and capacity hazards for the instruction in ID.
module hazard_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int RIDX_W  = 5,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chk_valid,
    input  logic [RIDX_W-1:0] rs1,
    input  logic [RIDX_W-1:0] rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic [RIDX_W-1:0] rd,
    input  logic              is_load,
    input  logic              set_en,
    input  logic [RIDX_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [RIDX_W-1:0] clr_idx,
    output logic              raw,
    output logic              waw,
    output logic              full,
    output logic [OUT_W-1:0]  count
);

    logic [NREG-1:0] pend;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            clr_hit;

    assign rs1_hit = use_rs1 & pend[rs1] & (rs1 != '0);
    assign rs2_hit = use_rs2 & pend[rs2] & (rs2 != '0);

    assign raw  = chk_valid & (rs1_hit | rs2_hit);
    assign waw  = chk_valid & is_load & pend[rd] & (rd != '0);
    assign full = chk_valid & is_load & (count == OUT_W'(MAX_OUT));

    // x0 loads are counted but never marked, so their completion must still count down.
    assign clr_hit = clr_en & ((clr_idx == '0) | pend[clr_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= '0;
            count <= '0;
        end else begin
            if (set_en && set_idx != '0) begin
                pend[set_idx] <= 1'b1;
            end
            if (clr_hit) begin
                pend[clr_idx] <= 1'b0;
            end
            count <= next_count(count, set_en, clr_hit);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load scoreboard, stall/flush control and
// halt-drain FSM. HAZ_PERF_CNT_EN adds stall/flush/raw event counters.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int RIDX_W    = 5,
    parameter int MAX_OUT   = 2,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [RIDX_W-1:0] id_rs1,
    input  logic [RIDX_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [RIDX_W-1:0] id_rd,
    input  logic              id_is_load,
    input  logic              id_halt,
    input  logic              ex_br_taken,
    input  logic              ld_done,
    input  logic [RIDX_W-1:0] ld_done_rd,
    input  logic              resume,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_bubble,
    output logic              flush_if_id,
    output logic              halted,
    output logic [OUT_W-1:0]  outstanding
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       raw_cnt
`endif
);

    localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

    hz_state_t   state;
    logic [DW-1:0] drain_cnt;
    logic        raw;
    logic        waw;
    logic        full;
    logic        stall;
    logic        issue;
    logic        in_run;

    hazard_scoreboard #(
        .NREG    (NREG),
        .RIDX_W  (RIDX_W),
        .MAX_OUT (MAX_OUT)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .chk_valid (id_valid),
        .rs1       (id_rs1),
        .rs2       (id_rs2),
        .use_rs1   (id_use_rs1),
        .use_rs2   (id_use_rs2),
        .rd        (id_rd),
        .is_load   (id_is_load),
        .set_en    (issue & id_is_load),
        .set_idx   (id_rd),
        .clr_en    (ld_done),
        .clr_idx   (ld_done_rd),
        .raw       (raw),
        .waw       (waw),
        .full      (full),
        .count     (outstanding)
    );

    assign in_run = (state == ST_RUN);
    assign stall  = raw | waw | full;
    assign issue  = id_valid & ~stall & ~ex_br_taken & in_run;
    assign halted = (state == ST_HALTED);

    // Outside RUN the front end is frozen and redirects are ignored.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        priority case (1'b1)
            !in_run: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
            ex_br_taken: begin
                flush_if_id  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            stall: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (issue && id_halt) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DW'(DRAIN_CYC);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end else if (outstanding == '0) begin
                        state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            raw_cnt   <= '0;
        end else begin
            if (in_run && stall && !ex_br_taken) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ex_br_taken) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (raw) begin
                raw_cnt <= raw_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
